// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit_if
// Brief    : D-stage instruction and flush in; E-stage controls and hazard
//            controls out.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_ctrl_unit_if;
    logic [31:0] instrD;
    logic        flushE_in;
    logic [2:0]  ImmSrcD;
    logic        illegalD;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        ALUSrcE;
    logic        luiE;
    logic [1:0]  ResultSrcE;
    logic [1:0]  JumpE;
    logic [2:0]  BranchE;
    logic [4:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushM;
    logic        mdStartE;
    logic        mdDoneE;

    modport master (
        output instrD, flushE_in,
        input  ImmSrcD, illegalD, RegWriteE, MemWriteE, ALUSrcE, luiE,
               ResultSrcE, JumpE, BranchE, ALUControlE, RdE, Rs1E, Rs2E,
               stallF, stallD, stallE, flushM, mdStartE, mdDoneE
    );

    modport slave (
        input  instrD, flushE_in,
        output ImmSrcD, illegalD, RegWriteE, MemWriteE, ALUSrcE, luiE,
               ResultSrcE, JumpE, BranchE, ALUControlE, RdE, Rs1E, Rs2E,
               stallF, stallD, stallE, flushM, mdStartE, mdDoneE
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_unit
// Brief    : RV32I(+M) decoder, E-stage control register and hazard unit with
//            multi-cycle muldiv occupancy of the E stage.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl_unit #(
    parameter int MULDIV_EN = 1,
    parameter int MUL_LAT   = 2,
    parameter int DIV_LAT   = 8
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_unit_if.slave bus
);
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [4:0] c_ALU_SUB = 5'b0_0001;
    localparam logic [4:0] c_ALU_SRL = 5'b0_1000;
    localparam logic [4:0] c_ALU_SRA = 5'b0_1001;

    localparam logic [3:0] c_MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] c_DIV_CNT = 4'(DIV_LAT - 1);

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       alu_src;
        logic       lui;
        logic [1:0] result_src;
        logic [1:0] jump;
        logic [2:0] branch;
        logic [4:0] alu_ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } e_ctrl_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    e_ctrl_t    w_dec;
    logic [2:0] w_imm_src;
    logic       w_legal;
    logic       w_is_md;
    logic       w_load_use;
    logic       w_hold;
    state_t     w_state;
    e_ctrl_t    w_e_next;
    logic [3:0] w_cnt_next;
    logic       w_md_start_next;
    e_ctrl_t    r_e;
    logic [3:0] r_cnt;
    logic       r_md_start;

    assign w_opcode = bus.instrD[6:0];
    assign w_funct3 = bus.instrD[14:12];
    assign w_funct7 = bus.instrD[31:25];

    function automatic logic [4:0] base_alu(input logic [2:0] f3);
        logic [4:0] v;
        case (f3)
            3'b000:  v = 5'b0_0000;
            3'b001:  v = 5'b0_0111;
            3'b010:  v = 5'b0_0101;
            3'b011:  v = 5'b0_0110;
            3'b100:  v = 5'b0_0100;
            3'b101:  v = c_ALU_SRL;
            3'b110:  v = 5'b0_0011;
            default: v = 5'b0_0010;
        endcase
        return v;
    endfunction

    always_comb begin
        w_dec     = '0;
        w_imm_src = 3'b000;
        w_legal   = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_dec.reg_write = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_legal        = 1'b1;
                    w_dec.alu_ctrl = base_alu(w_funct3);
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
                    w_legal        = 1'b1;
                    w_dec.alu_ctrl = c_ALU_SUB;
                end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                    w_legal        = 1'b1;
                    w_dec.alu_ctrl = c_ALU_SRA;
                end else if (MULDIV_EN != 0 && w_funct7 == 7'b0000001) begin
                    w_legal        = 1'b1;
                    w_dec.alu_ctrl = {2'b10, w_funct3};
                end
            end
            c_OP_IMM: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = base_alu(w_funct3);
                // Shift-immediates carry funct7 in the immediate field.
                if (w_funct3 == 3'b001) begin
                    w_legal = (w_funct7 == 7'b0000000);
                end else if (w_funct3 == 3'b101) begin
                    w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                    if (w_funct7 == 7'b0100000) begin
                        w_dec.alu_ctrl = c_ALU_SRA;
                    end
                end else begin
                    w_legal = 1'b1;
                end
            end
            c_OP_LOAD: begin
                w_legal          = (w_funct3 == 3'b010);
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b01;
            end
            c_OP_STORE: begin
                w_legal         = (w_funct3 == 3'b010);
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_imm_src       = 3'b001;
            end
            c_OP_BRANCH: begin
                w_legal        = 1'b1;
                w_imm_src      = 3'b010;
                w_dec.alu_ctrl = c_ALU_SUB;
                case (w_funct3)
                    3'b000:  w_dec.branch = 3'b001;
                    3'b001:  w_dec.branch = 3'b010;
                    3'b100:  w_dec.branch = 3'b011;
                    3'b101:  w_dec.branch = 3'b100;
                    3'b110:  w_dec.branch = 3'b101;
                    3'b111:  w_dec.branch = 3'b110;
                    default: w_legal      = 1'b0;
                endcase
            end
            c_OP_JAL: begin
                w_legal          = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 2'b01;
                w_imm_src        = 3'b011;
            end
            c_OP_JALR: begin
                w_legal          = (w_funct3 == 3'b000);
                w_dec.reg_write  = 1'b1;
                w_dec.alu_src    = 1'b1;
                w_dec.result_src = 2'b10;
                w_dec.jump       = 2'b10;
            end
            c_OP_LUI: begin
                w_legal         = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.lui       = 1'b1;
                w_imm_src       = 3'b100;
            end
            default: w_legal = 1'b0;
        endcase
        // Unsupported encodings become a full bubble, indices included.
        if (w_legal) begin
            w_dec.rd  = bus.instrD[11:7];
            w_dec.rs1 = bus.instrD[19:15];
            w_dec.rs2 = bus.instrD[24:20];
        end else begin
            w_dec     = '0;
            w_imm_src = 3'b000;
        end
    end

    assign w_is_md    = w_dec.alu_ctrl[4];
    assign w_state    = (r_cnt != 4'd0) ? BUSY : IDLE;
    assign w_hold     = (w_state == BUSY);
    assign w_load_use = (r_e.result_src == 2'b01) && r_e.reg_write && (r_e.rd != 5'd0) &&
                        ((r_e.rd == bus.instrD[19:15]) || (r_e.rd == bus.instrD[24:20]));

    always_comb begin
        w_e_next        = r_e;
        w_cnt_next      = r_cnt;
        w_md_start_next = 1'b0;
        case (w_state)
            BUSY: w_cnt_next = r_cnt - 4'd1;
            default: begin
                if (bus.flushE_in || w_load_use) begin
                    w_e_next = '0;
                end else begin
                    w_e_next = w_dec;
                    if (w_is_md) begin
                        w_cnt_next      = w_funct3[2] ? c_DIV_CNT : c_MUL_CNT;
                        w_md_start_next = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e        <= '0;
            r_cnt      <= 4'd0;
            r_md_start <= 1'b0;
        end else begin
            r_e        <= w_e_next;
            r_cnt      <= w_cnt_next;
            r_md_start <= w_md_start_next;
        end
    end

    assign bus.ImmSrcD     = w_imm_src;
    assign bus.illegalD    = ~w_legal;
    assign bus.RegWriteE   = r_e.reg_write;
    assign bus.MemWriteE   = r_e.mem_write;
    assign bus.ALUSrcE     = r_e.alu_src;
    assign bus.luiE        = r_e.lui;
    assign bus.ResultSrcE  = r_e.result_src;
    assign bus.JumpE       = r_e.jump;
    assign bus.BranchE     = r_e.branch;
    assign bus.ALUControlE = r_e.alu_ctrl;
    assign bus.RdE         = r_e.rd;
    assign bus.Rs1E        = r_e.rs1;
    assign bus.Rs2E        = r_e.rs2;
    assign bus.stallF      = w_load_use | w_hold;
    assign bus.stallD      = w_load_use | w_hold;
    assign bus.stallE      = w_hold;
    assign bus.flushM      = w_hold;
    assign bus.mdStartE    = r_md_start;
    assign bus.mdDoneE     = r_e.alu_ctrl[4] & (r_cnt == 4'd0);
endmodule
`default_nettype wire

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 SHALL have parameter MULDIV_EN, default 1, meaning RV32M decode and multi-cycle stall are enabled (0: M-encodings are illegal).
REQ-002 SHALL have parameter MUL_LAT, default 2, meaning E-stage occupancy in cycles of MUL* ops (range 1..15).
REQ-003 SHALL have parameter DIV_LAT, default 8, meaning E-stage occupancy in cycles of DIV*/REM* ops (range 1..15).
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 instrD  in  32  instruction in D stage.
REQ-007 flushE_in  in  1  taken branch/jump resolved in E; bubble the next E load.
REQ-008 ImmSrcD  out  3  combinational immediate select for D: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-009 illegalD  out  1  combinational; instrD is unsupported.
REQ-010 RegWriteE, MemWriteE, ALUSrcE, luiE  out  1 each  registered E-stage controls.
REQ-011 ResultSrcE  out  2  00 ALU, 01 load data, 10 PC+4.
REQ-012 JumpE  out  2  00 none, 01 JAL, 10 JALR.
REQ-013 BranchE  out  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU.
REQ-014 ALUControlE  out  5  0_0000 add, 0_0001 sub, 0_0010 and, 0_0011 or, 0_0100 xor, 0_0101 slt, 0_0110 sltu, 0_0111 sll, 0_1000 srl, 0_1001 sra; 1_0fff muldiv with fff = funct3.
REQ-015 RdE, Rs1E, Rs2E  out  5 each  registered register indices for forwarding.
REQ-016 stallF, stallD  out  1 each  hold PC and F/D register.
REQ-017 stallE  out  1  hold E-stage datapath registers.
REQ-018 flushM  out  1  insert bubble into E/M register.
REQ-019 mdStartE, mdDoneE  out  1 each  first / last E cycle of a muldiv op.

Function
REQ-020 Decode SHALL support R, I-ALU, load (LW), store (SW), branch, JAL, JALR, LUI; any other opcode/funct combination SHALL set illegalD=1 and decode to all-zero controls.
REQ-021 Muldiv op = opcode 0110011, funct7 0000001; latency L = MUL_LAT if funct3[2]=0, else DIV_LAT.
REQ-022 loadUse SHALL be ResultSrcE=01 & RegWriteE & RdE!=0 & (RdE==instrD[19:15] | RdE==instrD[24:20]).
REQ-023 A 4-bit counter cnt SHALL define the states IDLE (cnt=0) and BUSY (cnt!=0).
REQ-024 holdE SHALL be (cnt!=0).
REQ-025 E-register update priority SHALL be: holdE -> retain the E registers.
REQ-026 Next priority: flushE_in or loadUse -> load all-zero controls and indices (bubble).
REQ-027 Otherwise the E registers SHALL load the decoded controls of instrD.
REQ-028 When a muldiv op loads into E, cnt SHALL load L-1.
REQ-029 While cnt!=0, cnt SHALL decrement by 1 per cycle.
REQ-030 A muldiv op SHALL therefore occupy E for exactly L cycles; L=1 SHALL cause no hold.
REQ-031 stallF = stallD = loadUse | holdE; stallE = holdE; flushM = holdE.
REQ-032 flushE_in SHALL be ignored while holdE=1.
REQ-033 mdStartE SHALL be 1 in the first E cycle of a muldiv op (registered flag set on load).
REQ-034 mdDoneE SHALL be 1 when a muldiv op is in E and cnt=0.
REQ-035 MULDIV_EN=0 SHALL make cnt constant 0, and mdStartE and mdDoneE constant 0.

Reset
REQ-036 On rst=1, all E registers, cnt and mdStart flag SHALL clear to 0 immediately, without a clock edge, including mid-BUSY.
REQ-037 After reset, all outputs SHALL be 0 except the combinational ImmSrcD and illegalD, which follow instrD.
REQ-038 The first rising edge after rst falls SHALL load E normally.

Verification
REQ-039 Decode scenario: ADD, SUB, SRA, LW, SW, BNE, JAL, JALR, LUI each in turn -> E controls match REQ-011..014 on the next cycle; opcode 0000000 -> illegalD=1, bubble.
REQ-040 Load-use scenario: LW x5 in E, ADD x6,x5,x1 in D -> stallF=stallD=1 for 1 cycle, E gets bubble, ADD enters E the following cycle.
REQ-041 DIV scenario: DIV with DIV_LAT=8 -> stallE/stallF/stallD=1 for 7 cycles, mdStartE on cycle 1, mdDoneE on cycle 8, next instruction enters E on cycle 9.
REQ-042 MUL scenario: MUL_LAT=1 -> no stall; mdStartE and mdDoneE both 1 in the same cycle.
REQ-043 Flush scenario: flushE_in=1 with BEQ decoded in D -> E zeroed; flushE_in=1 during DIV BUSY -> no effect.
REQ-044 Reset scenario: rst asserted at cnt=4 -> cnt=0, all E outputs 0 asynchronously; MULDIV_EN=0 build -> MUL decodes illegalD=1.
